// File: rtl/instr_fetch_pkg.sv
// Shared constants and encodings for the fetch stage and its branch resolver.
package instr_fetch_pkg;

   // ADDI X31,X31,#0: decodes as a harmless non-branch
   localparam logic [31:0] BUBBLE_INSN = 32'h910003FF;
   localparam logic [10:0] HALT_OPCODE = 11'h7FF;

   typedef enum logic [1:0] {
      BR_SEQ   = 2'b00,
      BR_IMM26 = 2'b01,
      BR_REG   = 2'b10,
      BR_HALT  = 2'b11
   } br_sel_t;

   typedef enum logic [1:0] {
      FS_BOOT = 2'b00,
      FS_RUN  = 2'b01,
      FS_HALT = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_branch_target.sv
// Branch resolver: sign-extends word offsets, forms targets off pcDec and picks
// the winning branch kind (register > imm26 > CBZ > B.LT).
module instr_fetch_branch_target
   import instr_fetch_pkg::*;
#(
   parameter int PC_WIDTH = 64
) (
   input  logic [PC_WIDTH-1:0] pcDec,
   input  br_sel_t             brSel,
   input  logic                isCbz,
   input  logic                isBlt,
   input  logic [18:0]         condAddr19,
   input  logic [25:0]         condAddr26,
   input  logic                zeroFlag,
   input  logic                negFlag,
   input  logic                overflowFlag,
   input  logic [PC_WIDTH-1:0] brRegVal,
   output logic [PC_WIDTH-1:0] target,
   output logic                taken
);

   logic [PC_WIDTH-1:0] off19;
   logic [PC_WIDTH-1:0] off26;

   // word offsets become byte offsets; sums wrap naturally at 2^PC_WIDTH
   assign off19 = {{(PC_WIDTH-21){condAddr19[18]}}, condAddr19, 2'b00};
   assign off26 = {{(PC_WIDTH-28){condAddr26[25]}}, condAddr26, 2'b00};

   always_comb begin
      target = pcDec + off19;
      taken  = 1'b0;
      if (brSel == BR_REG) begin
         target = brRegVal;
         taken  = 1'b1;
      end else if (brSel == BR_IMM26) begin
         target = pcDec + off26;
         taken  = 1'b1;
      end else if (isCbz && zeroFlag) begin
         target = pcDec + off19;
         taken  = 1'b1;
      end else if (isBlt && (negFlag ^ overflowFlag)) begin
         target = pcDec + off19;
         taken  = 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, resolves last cycle's decoded branch, squashes the
// wrong-path fetch on redirect, and halts on the all-ones instruction.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int                  PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic [31:0]         imemData,
   input  logic [1:0]          brTaken,
   input  logic                isCbz,
   input  logic                isBlt,
   input  logic [18:0]         condAddr19,
   input  logic [25:0]         condAddr26,
   input  logic                zeroFlag,
   input  logic                negFlag,
   input  logic                overflowFlag,
   input  logic [PC_WIDTH-1:0] brRegVal,
   output logic [PC_WIDTH-1:0] instrAddr,
   output logic [31:0]         instruction,
   output logic [PC_WIDTH-1:0] pcDec,
   output logic                redirect,
   output logic                halted
);

   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

   fetch_state_t        state;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_dec_q;
   logic [PC_WIDTH-1:0] bt_target;
   logic                bt_taken;
   logic                run;
   logic                halt_req;
   br_sel_t             br_sel;

   assign br_sel = br_sel_t'(brTaken);

   instr_fetch_branch_target #(
      .PC_WIDTH (PC_WIDTH)
   ) u_branch_target (
      .pcDec        (pc_dec_q),
      .brSel        (br_sel),
      .isCbz        (isCbz),
      .isBlt        (isBlt),
      .condAddr19   (condAddr19),
      .condAddr26   (condAddr26),
      .zeroFlag     (zeroFlag),
      .negFlag      (negFlag),
      .overflowFlag (overflowFlag),
      .brRegVal     (brRegVal),
      .target       (bt_target),
      .taken        (bt_taken)
   );

   // IF/ID comes out of reset holding brTaken=11, so branch inputs only matter in RUN
   assign run      = (state == FS_RUN);
   assign redirect = run && bt_taken && (br_sel != BR_HALT);
   assign halt_req = run && (br_sel == BR_HALT) && !stall;

   always_comb begin
      instruction = BUBBLE_INSN;
      case (state)
         FS_BOOT: instruction = imemData;
         FS_RUN:  instruction = (redirect || halt_req) ? BUBBLE_INSN : imemData;
         default: instruction = BUBBLE_INSN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= FS_BOOT;
         pc       <= RESET_PC;
         pc_dec_q <= RESET_PC;
      end else begin
         case (state)
            FS_BOOT: begin
               state    <= FS_RUN;
               pc       <= pc + PC_STEP;
               pc_dec_q <= pc;
            end
            FS_RUN: begin
               // redirect outranks stall: the squashed slot must not be held
               if (redirect) begin
                  pc       <= bt_target;
                  pc_dec_q <= pc;
               end else if (halt_req) begin
                  state <= FS_HALT;
               end else if (!stall) begin
                  pc       <= pc + PC_STEP;
                  pc_dec_q <= pc;
               end
            end
            FS_HALT: state <= FS_HALT;
            default: state <= FS_BOOT;
         endcase
      end
   end

   assign instrAddr = pc;
   assign pcDec     = pc_dec_q;
   assign halted    = (state == FS_HALT);

endmodule
